// File: rtl/game_sequencer.sv
// game_sequencer -- control FSM for a word-scramble game.
//
// Flow: IDLE -> (login) SETUP -> PLAY <-> PAUSE -> GAMEOVER -> SETUP ...
// SETUP can also step through difficulty modes and roll into the
// top-score pages; SETUP/PAUSE logout passes through a one-cycle LOGOUT.
//
// Ports
//   clk, rst             clock (rising), synchronous active-low reset
//   log_on, pwd_pls      login level, logout pulse
//   start_pls, load_pls  start/advance/scramble and mode-step/flip/exit pulses
//   pause_pls            pause toggle
//   is_correct, time_out word solved, round timer expired
//   pid_in, is_guest_in  player info, latched while in GAMEOVER
//   idx_in1/2            letter indices, mirrored to idx_out1/2 in PLAY
//   ctrl_sig             display code: IDLE 0, SETUP 1, PLAY 2, GAMEOVER 3,
//                        TOPSCORE 4+page, PAUSE 6 (LOGOUT shows 0)
//   log_out, pid_out, is_guest_out, score, lett_num, mode_disp (mode+4)
//   scram_pls, flip_pls  start/load pulses forwarded only during PLAY
//   timer_en, timer_reconfig
//
// Optional feature: define STREAK_BONUS_EN to award 2 points for the third
// and later consecutive correct answers.
//
// Every output is a register; next values are computed combinationally
// from the current state and the inputs sampled at the same edge.

module game_sequencer #(
  parameter int MODE_CNT  = 3,
  parameter int SCORE_W   = 7,
  parameter int IDX_W     = 3,
  parameter int TOP_PAGES = 2,
  localparam int MW       = (MODE_CNT > 1) ? $clog2(MODE_CNT) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               log_on,
  input  logic               pwd_pls,
  input  logic               start_pls,
  input  logic               load_pls,
  input  logic               pause_pls,
  input  logic               is_correct,
  input  logic               time_out,
  input  logic [2:0]         pid_in,
  input  logic               is_guest_in,
  input  logic [IDX_W-1:0]   idx_in1,
  input  logic [IDX_W-1:0]   idx_in2,
  output logic [2:0]         ctrl_sig,
  output logic               log_out,
  output logic [2:0]         pid_out,
  output logic               is_guest_out,
  output logic [SCORE_W-1:0] score,
  output logic [MW-1:0]      lett_num,
  output logic [3:0]         mode_disp,
  output logic               scram_pls,
  output logic               flip_pls,
  output logic [IDX_W-1:0]   idx_out1,
  output logic [IDX_W-1:0]   idx_out2,
  output logic               timer_en,
  output logic               timer_reconfig
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_PLAY, S_GAMEOVER, S_TOPSCORE, S_PAUSE, S_LOGOUT
  } state_t;

  localparam logic [MW-1:0] MODE_LAST = MW'(MODE_CNT - 1);

  state_t              state, nState;
  logic [MW-1:0]       mode, nMode;
  logic                page, nPage;
  logic [SCORE_W-1:0]  nScore, bumped;
  logic [MW-1:0]       nLett;
  logic                nLogOut, nTimerEn, nGuest;
  logic [2:0]          nPid;
  logic [SCORE_W:0]    sum;

`ifdef STREAK_BONUS_EN
  logic [1:0] streak, nStreak, streakBase;
  // A flip in the same cycle as an answer breaks the run first, so that
  // answer counts as the start of a new streak.
  assign streakBase = load_pls ? 2'd0 : streak;
  assign sum = {1'b0, score} + (streakBase[1] ? (SCORE_W+1)'(2) : (SCORE_W+1)'(1));
`else
  assign sum = {1'b0, score} + (SCORE_W+1)'(1);
`endif

  assign bumped = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];

  function automatic logic [2:0] dispCode(input state_t s, input logic p);
    case (s)
      S_SETUP:    dispCode = 3'd1;
      S_PLAY:     dispCode = 3'd2;
      S_GAMEOVER: dispCode = 3'd3;
      S_TOPSCORE: dispCode = {2'b10, p};
      S_PAUSE:    dispCode = 3'd6;
      default:    dispCode = 3'd0;
    endcase
  endfunction

  always_comb begin
    nState   = state;
    nMode    = mode;
    nPage    = page;
    nScore   = score;
    nLett    = lett_num;
    nLogOut  = log_out;
    nTimerEn = timer_en;
    nPid     = pid_out;
    nGuest   = is_guest_out;
`ifdef STREAK_BONUS_EN
    nStreak  = streak;
`endif
    case (state)
      S_IDLE: begin
        nTimerEn = 1'b0;
        nMode    = '0;
        if (log_on) nState = S_SETUP;
      end
      S_SETUP: begin
        if (pwd_pls) begin
          nLogOut = 1'b1;
          nState  = S_LOGOUT;
        end else if (load_pls) begin
          if (mode == MODE_LAST) begin
            nMode  = '0;
            nPage  = 1'b0;
            nState = S_TOPSCORE;
          end else begin
            nMode = mode + MW'(1);
          end
        end else if (start_pls) begin
          nScore   = '0;
          nLett    = mode;
          nTimerEn = 1'b1;
          nState   = S_PLAY;
`ifdef STREAK_BONUS_EN
          nStreak  = 2'd0;
`endif
        end
      end
      S_PLAY: begin
`ifdef STREAK_BONUS_EN
        if (load_pls) nStreak = 2'd0;
`endif
        if (is_correct) begin
          nScore = bumped;
`ifdef STREAK_BONUS_EN
          nStreak = (streakBase == 2'd3) ? 2'd3 : streakBase + 2'd1;
`endif
        end
        // Timer expiry outranks a pause request in the same cycle.
        if (time_out) begin
          nState   = S_GAMEOVER;
          nTimerEn = 1'b0;
        end else if (pause_pls) begin
          nState   = S_PAUSE;
          nTimerEn = 1'b0;
`ifdef STREAK_BONUS_EN
          nStreak  = 2'd0;
`endif
        end
      end
      S_PAUSE: begin
        if (pwd_pls) begin
          nLogOut = 1'b1;
          nState  = S_LOGOUT;
        end else if (pause_pls) begin
          nState   = S_PLAY;
          nTimerEn = 1'b1;
        end
      end
      S_GAMEOVER: begin
        nPid   = pid_in;
        nGuest = is_guest_in;
        if (start_pls) nState = S_SETUP;
      end
      S_LOGOUT: begin
        nLogOut  = 1'b0;
        nTimerEn = 1'b0;
        nMode    = '0;
        nState   = S_IDLE;
      end
      S_TOPSCORE: begin
        if (start_pls) nPage = (TOP_PAGES == 2) ? ~page : 1'b0;
        else if (load_pls) nState = S_IDLE;
      end
      default: nState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= S_IDLE;
      mode           <= '0;
      page           <= 1'b0;
      ctrl_sig       <= '0;
      log_out        <= 1'b0;
      pid_out        <= '0;
      is_guest_out   <= 1'b0;
      score          <= '0;
      lett_num       <= '0;
      mode_disp      <= '0;
      scram_pls      <= 1'b0;
      flip_pls       <= 1'b0;
      idx_out1       <= '0;
      idx_out2       <= '0;
      timer_en       <= 1'b0;
      timer_reconfig <= 1'b1;
`ifdef STREAK_BONUS_EN
      streak         <= 2'd0;
`endif
    end else begin
      state          <= nState;
      mode           <= nMode;
      page           <= nPage;
      ctrl_sig       <= dispCode(nState, nPage);
      log_out        <= nLogOut;
      pid_out        <= nPid;
      is_guest_out   <= nGuest;
      score          <= nScore;
      lett_num       <= nLett;
      mode_disp      <= 4'(nMode) + 4'd4;
      scram_pls      <= (state == S_PLAY) & start_pls;
      flip_pls       <= (state == S_PLAY) & load_pls;
      if (state == S_PLAY) begin
        idx_out1 <= idx_in1;
        idx_out2 <= idx_in2;
      end
      timer_en       <= nTimerEn;
      timer_reconfig <= (nState == S_IDLE);
`ifdef STREAK_BONUS_EN
      streak         <= nStreak;
`endif
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: a table of directed vectors, a hand-written
// streak/flip/latch sequence, then randomized traffic against a
// behavioural model that tracks the game phase and score arithmetic.
module tb_game_sequencer;
  localparam int MODE_CNT  = 3;
  localparam int SCORE_W   = 3;
  localparam int IDX_W     = 3;
  localparam int TOP_PAGES = 2;
  localparam int MW        = $clog2(MODE_CNT);
  localparam int SMAX      = (1 << SCORE_W) - 1;

  logic clk = 0, rst = 0, log_on = 0, pwd_pls = 0, start_pls = 0;
  logic load_pls = 0, pause_pls = 0, is_correct = 0, time_out = 0;
  logic [2:0] pid_in = 0;
  logic is_guest_in = 0;
  logic [IDX_W-1:0] idx_in1 = 0, idx_in2 = 0;
  logic [2:0] ctrl_sig, pid_out;
  logic log_out, is_guest_out, scram_pls, flip_pls, timer_en, timer_reconfig;
  logic [SCORE_W-1:0] score;
  logic [MW-1:0] lett_num;
  logic [3:0] mode_disp;
  logic [IDX_W-1:0] idx_out1, idx_out2;

  game_sequencer #(.MODE_CNT(MODE_CNT), .SCORE_W(SCORE_W), .IDX_W(IDX_W),
                   .TOP_PAGES(TOP_PAGES)) dut (
    .clk(clk), .rst(rst), .log_on(log_on), .pwd_pls(pwd_pls),
    .start_pls(start_pls), .load_pls(load_pls), .pause_pls(pause_pls),
    .is_correct(is_correct), .time_out(time_out), .pid_in(pid_in),
    .is_guest_in(is_guest_in), .idx_in1(idx_in1), .idx_in2(idx_in2),
    .ctrl_sig(ctrl_sig), .log_out(log_out), .pid_out(pid_out),
    .is_guest_out(is_guest_out), .score(score), .lett_num(lett_num),
    .mode_disp(mode_disp), .scram_pls(scram_pls), .flip_pls(flip_pls),
    .idx_out1(idx_out1), .idx_out2(idx_out2), .timer_en(timer_en),
    .timer_reconfig(timer_reconfig));

  always #5 clk = ~clk;

  int nVec = 0, nFail = 0;

  task automatic check(input string name, input int act, input int exp);
    nVec++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int P_IDLE = 0, P_SETUP = 1, P_PLAY = 2, P_OVER = 3;
  localparam int P_TOP = 4, P_PAUSE = 5, P_LOGOUT = 6;
  int ph, md, pg, stk, sc, lett, pid, gst, ten, lo, ix1, ix2, scr, flp;
  bit inReset;

  task automatic modelStep();
    int inc;
    if (!rst) begin
      ph = P_IDLE; md = 0; pg = 0; stk = 0; sc = 0; lett = 0; pid = 0;
      gst = 0; ten = 0; lo = 0; ix1 = 0; ix2 = 0; scr = 0; flp = 0;
      inReset = 1;
      return;
    end
    inReset = 0;
    scr = 0; flp = 0;
    case (ph)
      P_IDLE: begin ten = 0; md = 0; if (log_on) ph = P_SETUP; end
      P_SETUP:
        if (pwd_pls) begin lo = 1; ph = P_LOGOUT; end
        else if (load_pls) begin
          if (md == MODE_CNT - 1) begin md = 0; pg = 0; ph = P_TOP; end
          else md++;
        end else if (start_pls) begin
          sc = 0; lett = md; ten = 1; stk = 0; ph = P_PLAY;
        end
      P_PLAY: begin
        scr = start_pls; flp = load_pls; ix1 = idx_in1; ix2 = idx_in2;
        if (load_pls) stk = 0;
        if (is_correct) begin
`ifdef STREAK_BONUS_EN
          inc = (stk >= 2) ? 2 : 1;
`else
          inc = 1;
`endif
          sc = (sc + inc > SMAX) ? SMAX : sc + inc;
          stk = (stk >= 3) ? 3 : stk + 1;
        end
        if (time_out) begin ph = P_OVER; ten = 0; end
        else if (pause_pls) begin ph = P_PAUSE; ten = 0; stk = 0; end
      end
      P_PAUSE:
        if (pwd_pls) begin lo = 1; ph = P_LOGOUT; end
        else if (pause_pls) begin ph = P_PLAY; ten = 1; end
      P_OVER: begin
        pid = pid_in; gst = is_guest_in;
        if (start_pls) ph = P_SETUP;
      end
      P_LOGOUT: begin lo = 0; ten = 0; md = 0; ph = P_IDLE; end
      default: // P_TOP
        if (start_pls) pg = (pg + 1) % TOP_PAGES;
        else if (load_pls) ph = P_IDLE;
    endcase
  endtask

  function automatic int expCtrl();
    if (inReset) return 0;
    case (ph)
      P_TOP:    return 4 + pg;
      P_PAUSE:  return 6;
      P_LOGOUT: return 0;
      default:  return ph;
    endcase
  endfunction

  task automatic checkModel();
    check("m_ctrl", ctrl_sig, expCtrl());
    check("m_score", score, sc);
    check("m_lett", lett_num, lett);
    check("m_mode_disp", mode_disp, inReset ? 0 : md + 4);
    check("m_timer_en", timer_en, ten);
    check("m_reconfig", timer_reconfig, (ph == P_IDLE) ? 1 : 0);
    check("m_log_out", log_out, lo);
    check("m_scram", scram_pls, scr);
    check("m_flip", flip_pls, flp);
    check("m_idx1", idx_out1, ix1);
    check("m_idx2", idx_out2, ix2);
    check("m_pid", pid_out, pid);
    check("m_guest", is_guest_out, gst);
  endtask

  task automatic tick();
    modelStep();
    @(posedge clk);
    #1;
    checkModel();
  endtask

  task automatic setIn(input bit r, lg, pw, st, ld, pa, co, to);
    rst = r; log_on = lg; pwd_pls = pw; start_pls = st; load_pls = ld;
    pause_pls = pa; is_correct = co; time_out = to;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit r, lg, pw, st, ld, pa, co, to;
    int ctrl, sc, ten, rc, md, lo;
  } vec_t;
  vec_t tbl[$];

  task automatic addRow(input bit r, lg, pw, st, ld, pa, co, to,
                        input int ctrl, s, ten, rc, md, lo);
    vec_t v;
    v.r = r; v.lg = lg; v.pw = pw; v.st = st; v.ld = ld; v.pa = pa;
    v.co = co; v.to = to; v.ctrl = ctrl; v.sc = s; v.ten = ten;
    v.rc = rc; v.md = md; v.lo = lo;
    tbl.push_back(v);
  endtask

`ifdef STREAK_BONUS_EN
  int satExp[9] = '{1, 2, 4, 6, 7, 7, 7, 7, 7};
  int runExp[6] = '{1, 2, 4, 6, 6, 7};
`else
  int satExp[9] = '{1, 2, 3, 4, 5, 6, 7, 7, 7};
  int runExp[6] = '{1, 2, 3, 4, 4, 5};
`endif

  initial begin
    //     r lg pw st ld pa co to   ctrl sc ten rc md lo
    addRow(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0); // reset
    addRow(1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 4, 0); // idle holds
    addRow(1, 1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 4, 0); // login
    addRow(1, 0, 0, 0, 1, 0, 0, 0,   1, 0, 0, 0, 5, 0); // mode 1
    addRow(1, 0, 0, 0, 1, 0, 0, 0,   1, 0, 0, 0, 6, 0); // mode 2
    addRow(1, 0, 0, 0, 1, 0, 0, 0,   4, 0, 0, 0, 4, 0); // wrap -> top
    addRow(1, 0, 0, 1, 0, 0, 0, 0,   5, 0, 0, 0, 4, 0); // page 1
    addRow(1, 0, 0, 1, 0, 0, 0, 0,   4, 0, 0, 0, 4, 0); // page 0
    addRow(1, 0, 0, 0, 1, 0, 0, 0,   0, 0, 0, 1, 4, 0); // exit -> idle
    addRow(1, 1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 4, 0);
    addRow(1, 0, 0, 1, 0, 0, 0, 0,   2, 0, 1, 0, 4, 0); // play
    addRow(1, 0, 0, 0, 0, 0, 1, 0,   2, 1, 1, 0, 4, 0);
    addRow(1, 0, 0, 0, 0, 0, 1, 0,   2, 2, 1, 0, 4, 0);
    addRow(1, 0, 0, 0, 0, 1, 0, 0,   6, 2, 0, 0, 4, 0); // pause
    addRow(1, 0, 0, 0, 0, 0, 1, 0,   6, 2, 0, 0, 4, 0); // answer ignored
    addRow(1, 0, 0, 0, 0, 1, 0, 0,   2, 2, 1, 0, 4, 0); // resume
    addRow(1, 0, 0, 0, 0, 0, 1, 1,   3, 3, 0, 0, 4, 0); // timeout+correct
    addRow(1, 0, 0, 1, 0, 0, 0, 0,   1, 3, 0, 0, 4, 0); // score held
    addRow(1, 0, 0, 1, 0, 0, 0, 0,   2, 0, 1, 0, 4, 0); // new game
    for (int k = 0; k < 9; k++)
      addRow(1, 0, 0, 0, 0, 0, 1, 0, 2, satExp[k], 1, 0, 4, 0);
    addRow(1, 0, 0, 0, 0, 1, 0, 1,   3, 7, 0, 0, 4, 0); // timeout beats pause
    addRow(1, 0, 0, 1, 0, 0, 0, 0,   1, 7, 0, 0, 4, 0);
    addRow(1, 0, 1, 0, 1, 0, 0, 0,   0, 7, 0, 0, 4, 1); // pwd beats load
    addRow(1, 0, 0, 0, 0, 0, 0, 0,   0, 7, 0, 1, 4, 0); // logout -> idle
    addRow(1, 1, 0, 0, 0, 0, 0, 0,   1, 7, 0, 0, 4, 0);
    addRow(1, 0, 0, 1, 0, 0, 0, 0,   2, 0, 1, 0, 4, 0);
    addRow(1, 0, 0, 0, 0, 0, 1, 0,   2, 1, 1, 0, 4, 0);
    addRow(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0); // mid-game reset
    addRow(1, 1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 4, 0);

    foreach (tbl[i]) begin
      setIn(tbl[i].r, tbl[i].lg, tbl[i].pw, tbl[i].st, tbl[i].ld,
            tbl[i].pa, tbl[i].co, tbl[i].to);
      tick();
      check($sformatf("t%0d_ctrl", i), ctrl_sig, tbl[i].ctrl);
      check($sformatf("t%0d_score", i), score, tbl[i].sc);
      check($sformatf("t%0d_ten", i), timer_en, tbl[i].ten);
      check($sformatf("t%0d_reconfig", i), timer_reconfig, tbl[i].rc);
      check($sformatf("t%0d_mode_disp", i), mode_disp, tbl[i].md);
      check($sformatf("t%0d_log_out", i), log_out, tbl[i].lo);
    end

    // Streak run, flip, scramble forwarding, index mirror, GAMEOVER latch.
    setIn(1, 0, 0, 1, 0, 0, 0, 0); tick();
    check("h_start_ctrl", ctrl_sig, 2);
    check("h_no_scram", scram_pls, 0);
    idx_in1 = 5; idx_in2 = 2;
    for (int k = 0; k < 6; k++) begin
      setIn(1, 0, 0, 0, k == 4, 0, k != 4, 0); tick();
      check($sformatf("h_run%0d", k), score, runExp[k]);
    end
    check("h_idx1", idx_out1, 5);
    check("h_idx2", idx_out2, 2);
    setIn(1, 0, 0, 0, 1, 0, 0, 0); tick();
    check("h_flip", flip_pls, 1);
    setIn(1, 0, 0, 1, 0, 0, 0, 0); tick();
    check("h_scram", scram_pls, 1);
    check("h_flip_clr", flip_pls, 0);
    pid_in = 6; is_guest_in = 1;
    setIn(1, 0, 0, 0, 0, 0, 0, 1); tick();
    check("h_over", ctrl_sig, 3);
    setIn(1, 0, 0, 0, 0, 0, 0, 0); tick();
    check("h_pid", pid_out, 6);
    check("h_guest", is_guest_out, 1);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      setIn($urandom_range(0, 299) != 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 19) == 0, $urandom_range(0, 99) < 15,
            $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 8,
            $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 4);
      pid_in = 3'($urandom); is_guest_in = 1'($urandom);
      idx_in1 = IDX_W'($urandom); idx_in2 = IDX_W'($urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end
endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  MODE_CNT, 3, number of difficulty modes, legal 2..8; MW = clog2(MODE_CNT)
  SCORE_W, 7, score width
  IDX_W, 3, letter-index width
  TOP_PAGES, 2, top-score display pages, legal 1..2
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  in  1  clock, rising edge
  rst  in  1  reset, synchronous, active-low
  log_on  in  1  login request level
  pwd_pls  in  1  logout pulse
  start_pls  in  1  start/advance/scramble pulse
  load_pls  in  1  mode-step/flip/exit pulse
  pause_pls  in  1  pause toggle pulse
  is_correct  in  1  word-solved pulse
  time_out  in  1  round timer expired
  pid_in  in  3  player ID
  is_guest_in  in  1  guest flag
  idx_in1, idx_in2  in  IDX_W  letter indices to swap
  ctrl_sig  out  3  display mode: IDLE 0, SETUP 1, PLAY 2, GAMEOVER 3, TOPSCORE 4+page, PAUSE 6
  log_out  out  1  logout strobe
  pid_out, is_guest_out  out  3, 1  latched player info
  score  out  SCORE_W  game score
  lett_num  out  MW  active mode to word source
  mode_disp  out  4  mode + 4
  scram_pls, flip_pls  out  1  registered start_pls/load_pls during PLAY
  idx_out1, idx_out2  out  IDX_W  registered indices
  timer_en, timer_reconfig  out  1  timer control

Function
REQ-003 All outputs SHALL be registered; an input sampled at edge N SHALL affect outputs after edge N.
REQ-004 IDLE SHALL hold timer_reconfig=1, timer_en=0, mode=0, and SHALL go to SETUP when log_on=1, with timer_reconfig=0.
REQ-005 SETUP priority SHALL be pwd_pls > load_pls > start_pls; pwd_pls pulses log_out and goes to LOGOUT.
REQ-006 In SETUP, load_pls SHALL increment mode; at mode=MODE_CNT-1 it SHALL wrap mode to 0, set page=0 and go to TOPSCORE.
REQ-007 In SETUP, start_pls SHALL set score=0, lett_num=mode, timer_en=1, clear the streak and go to PLAY.
REQ-008 In PLAY, scram_pls/flip_pls SHALL mirror start_pls/load_pls, and idx_out SHALL mirror idx_in, every cycle.
REQ-009 In PLAY, is_correct SHALL add 1 to score and SHALL saturate at 2^SCORE_W-1.
REQ-010 In PLAY, time_out SHALL go to GAMEOVER with timer_en=0; a simultaneous is_correct SHALL still score; time_out SHALL beat pause_pls.
REQ-011 In PLAY, pause_pls SHALL go to PAUSE with timer_en=0; in PAUSE, scram/flip SHALL be 0, is_correct SHALL be ignored, pause_pls SHALL return to PLAY with timer_en=1, and pwd_pls SHALL go to LOGOUT.
REQ-012 GAMEOVER SHALL latch pid_in/is_guest_in to pid_out/is_guest_out, hold score, and return to SETUP on start_pls.
REQ-013 LOGOUT SHALL last one cycle, clear log_out and timer_en, and go to IDLE.
REQ-014 In TOPSCORE, start_pls SHALL advance page modulo TOP_PAGES; otherwise load_pls SHALL go to IDLE (start wins if both).

Reset
REQ-015 With rst=0 at an edge: state IDLE, mode/page/streak 0, all outputs 0 except timer_reconfig=1; a mid-game reset SHALL discard the score.

Configuration
REQ-016 With STREAK_BONUS_EN defined, a 2-bit saturating streak SHALL count correct answers; the third and later consecutive answers SHALL add 2 (saturating); flip_pls, PAUSE and game start SHALL clear the streak. Without the macro, every answer SHALL add 1 and no streak logic SHALL exist.

Verification
REQ-017 rst=0, then log_on=1 -> IDLE then SETUP; ctrl_sig 0 then 1; timer_reconfig 1 then 0.
REQ-018 SETUP with MODE_CNT=3: three load_pls -> mode_disp 5, then 6, then TOPSCORE with ctrl_sig=4; start_pls -> 5; start_pls -> 4; load_pls -> IDLE.
REQ-019 PLAY with SCORE_W=3: 9 is_correct -> score 7 (saturated); time_out together with is_correct at score 2 -> score 3, GAMEOVER.
REQ-020 PLAY: pause_pls -> ctrl_sig 6, timer_en 0, is_correct ignored; pause_pls -> PLAY, timer_en 1.
REQ-021 STREAK_BONUS_EN: four consecutive is_correct -> score 1,2,4,6; flip_pls then is_correct -> 7.
